perceptron_operand_loader: RTL and testbench

Streams perceptron operands in one word per beat over a valid/ready interface. Assembles them into a complete parallel operand set: N inputs x, N weights w, one bias b. Presents that set to the downstream Perceptron through a registered valid/ready output stage. A shadow buffer lets the next frame fill while the current one is held, so back-to-back frames sustain one word per cycle.

---
 rtl/perceptron_operand_loader.sv | 158 +++++++++++++++
 tb/tb_perceptron_operand_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_operand_loader.sv
// Streams x[0..N-1], w[0..N-1], b one word per beat into a shadow buffer and
// presents each complete frame through a registered valid/ready output stage.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module perceptron_operand_loader #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] x [N],
  output logic signed [DATA_WIDTH-1:0] w [N],
  output logic signed [DATA_WIDTH-1:0] b,
  output logic                         frame_err
);

  localparam int FRAME_LEN = 2 * N + 1;
  localparam int LAST_IDX  = 2 * N;
  localparam int IDX_W     = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_FULL,
    ST_RESYNC
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [IDX_W-1:0]              r_idx;
  logic signed [DATA_WIDTH-1:0]  r_shadow [FRAME_LEN];
  logic signed [DATA_WIDTH-1:0]  r_x [N];
  logic signed [DATA_WIDTH-1:0]  r_w [N];
  logic signed [DATA_WIDTH-1:0]  r_b;
  logic                          r_out_valid;
  logic                          r_frame_err;

  logic                          w_beat;
  logic                          w_fill_beat;
  logic                          w_at_last;
  logic                          w_slot_free;
  logic                          w_err_early;
  logic                          w_err_missing;
  logic                          w_frame_done;
  logic                          w_load_direct;
  logic                          w_load_shadow;
  logic                          w_load;
  logic signed [DATA_WIDTH-1:0]  w_bias;

  // Beat decode. The output slot counts as free when it is being consumed on
  // this same edge, which is what keeps back-to-back frames bubble-free.
  assign w_beat        = in_valid && in_ready;
  assign w_fill_beat   = (r_state == ST_FILL) && w_beat;
  assign w_at_last     = (r_idx == IDX_W'(LAST_IDX));
  assign w_slot_free   = !r_out_valid || out_ready;
  assign w_err_early   = w_fill_beat &&  in_last && !w_at_last;
  assign w_err_missing = w_fill_beat && !in_last &&  w_at_last;
  assign w_frame_done  = w_fill_beat &&  in_last &&  w_at_last;
  assign w_load_direct = w_frame_done && w_slot_free;
  assign w_load_shadow = (r_state == ST_FULL) && w_slot_free;
  assign w_load        = w_load_direct || w_load_shadow;
  assign w_bias        = w_load_direct ? in_data : r_shadow[LAST_IDX];

  // State register
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of process order.
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first, so every path assigns and no latch is inferred.
    w_state_next = r_state;
    unique case (r_state)
      ST_FILL: begin
        if (w_err_missing)                     w_state_next = ST_RESYNC;
        else if (w_frame_done && !w_slot_free) w_state_next = ST_FULL;
      end
      ST_FULL: begin
        if (w_slot_free) w_state_next = ST_FILL;
      end
      ST_RESYNC: begin
        if (w_beat && in_last) w_state_next = ST_FILL;
      end
      default: w_state_next = ST_FILL;
    endcase
  end

  // Output logic: accept input whenever the shadow buffer is not parked.
  always_comb begin
    in_ready = (r_state != ST_FULL);
  end

  // Word index: any terminating beat (good or bad) restarts the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_fill_beat) begin
      if (in_last || w_at_last) r_idx <= '0;
      else                      r_idx <= r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the shadow buffer is cleared on reset so no word from a frame cut
    // short by reset can ever reach the outputs.
    if (rst) begin
      for (int i = 0; i < FRAME_LEN; i++) r_shadow[i] <= '0;
    end else if (w_fill_beat) begin
      r_shadow[r_idx] <= in_data;
    end
  end

  // Registered output stage; x/w/b only change on a load, so they hold while
  // the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_x[i] <= '0;
        r_w[i] <= '0;
      end
      r_b <= '0;
    end else if (w_load) begin
      for (int i = 0; i < N; i++) begin
        r_x[i] <= r_shadow[i];
        r_w[i] <= r_shadow[N+i];
      end
      r_b <= w_bias;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            r_out_valid <= 1'b0;
    else if (w_load)    r_out_valid <= 1'b1;
    else if (out_ready) r_out_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_frame_err <= 1'b0;
    else     r_frame_err <= w_err_early || w_err_missing;
  end

  assign x         = r_x;
  assign w         = r_w;
  assign b         = r_b;
  assign out_valid = r_out_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_perceptron_operand_loader.sv
// Scoreboard bench: expected frames are queued when driven and compared when
// the downstream side consumes them.
module tb_perceptron_operand_loader;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int FL = 2 * N + 1;

  typedef int words_t [FL];
  typedef struct {
    logic signed [DW-1:0] x [N];
    logic signed [DW-1:0] w [N];
    logic signed [DW-1:0] b;
  } frame_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] x [N];
  logic signed [DW-1:0] w [N];
  logic signed [DW-1:0] b;
  logic                 frame_err;

  frame_t sb [$];
  int n_chk = 0;
  int n_err = 0;
  int err_pulses = 0;
  int frames_pushed = 0;
  int frames_seen = 0;
  int n_cyc = 0;

  perceptron_operand_loader #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .w         (w),
    .b         (b),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) n_cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Consumer side: a frame is consumed at the edge following a negedge that
  // sees out_valid && out_ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) err_pulses++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame", 32'(out_valid), 32'd0);
        end else begin
          frame_t e;
          e = sb.pop_front();
          for (int i = 0; i < N; i++) begin
            chk($sformatf("x%0d", i), 32'(x[i]), 32'(e.x[i]));
            chk($sformatf("w%0d", i), 32'(w[i]), 32'(e.w[i]));
          end
          chk("b", 32'(b), 32'(e.b));
          frames_seen++;
        end
      end
    end
  end

  task automatic push_expect(input words_t wd);
    frame_t e;
    for (int i = 0; i < N; i++) begin
      e.x[i] = DW'(wd[i]);
      e.w[i] = DW'(wd[N+i]);
    end
    e.b = DW'(wd[2*N]);
    sb.push_back(e);
    frames_pushed++;
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the beat was taken.
  task automatic send_word(input int data, input bit last);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = DW'(data);
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input words_t wd, input bit expect_out);
    if (expect_out) push_expect(wd);
    for (int i = 0; i < FL; i++) send_word(wd[i], i == FL - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    words_t f1, f2, f3, f4, f5, f6;
    int c0, base;
    f1 = '{1, 2, 3, 4, -1, -2, -3, -4, 5};
    f2 = '{10, 20, 30, 40, 1, 1, 1, 1, -7};
    f3 = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    f4 = '{11, 12, 13, 14, 15, 16, 17, 18, 19};
    f5 = '{31, -32, 33, -34, 35, -36, 37, -38, 127};
    f6 = '{-128, 0, 1, -1, 64, -64, 100, -100, 2};

    // Reset with junk on the input
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h5a; in_last = 1'b1; out_ready = 1'b1;
    @(posedge clk); in_data = 8'h33; in_last = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_x0", 32'(x[0]), 32'd0);
    chk("rst_w3", 32'(w[3]), 32'd0);
    chk("rst_b", 32'(b), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    idle(2);
    chk("junk_no_frame", 32'(out_valid), 32'd0);

    // Single frame with free output
    c0 = n_cyc;
    send_frame(f1, 1'b1);
    chk("single_latency", 32'(out_valid), 32'd1);
    chk("single_cycles", 32'(n_cyc - c0), 32'(FL));
    idle(1);
    chk("single_drop", 32'(out_valid), 32'd0);

    // Backpressure: frame 1 held, frame 2 parked in shadow
    out_ready = 1'b0;
    send_frame(f1, 1'b1);
    send_frame(f2, 1'b1);
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    chk("bp_held_x0", 32'(x[0]), 32'd1);
    chk("bp_held_b", 32'(b), 32'd5);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("bp_valid_kept", 32'(out_valid), 32'd1);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    chk("bp_new_x0", 32'(x[0]), 32'd10);
    chk("bp_new_b", 32'(b), 32'hFFFFFFF9);
    idle(2);
    chk("bp_still_held", 32'(x[3]), 32'd40);
    out_ready = 1'b1;
    idle(1);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Early last on word 5
    for (int i = 0; i < 5; i++) send_word(50 + i, i == 4);
    chk("early_err", 32'(frame_err), 32'd1);
    chk("early_no_valid", 32'(out_valid), 32'd0);
    idle(1);
    chk("early_err_pulse", 32'(frame_err), 32'd0);
    send_frame(f3, 1'b1);

    // Missing last, then resync through three junk words
    idle(1);
    for (int i = 0; i < FL; i++) send_word(70 + i, 1'b0);
    chk("missing_err", 32'(frame_err), 32'd1);
    idle(1);
    base = err_pulses;
    for (int i = 0; i < 3; i++) send_word(90 + i, i == 2);
    idle(2);
    chk("resync_no_err", 32'(err_pulses), 32'(base));
    chk("resync_no_valid", 32'(out_valid), 32'd0);
    send_frame(f6, 1'b1);
    idle(1);

    // Reset mid-frame while a frame is held
    out_ready = 1'b0;
    send_frame(f4, 1'b0);
    chk("pre_rst_x0", 32'(x[0]), 32'd11);
    for (int i = 0; i < 5; i++) send_word(60 + i, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_x0", 32'(x[0]), 32'd0);
    chk("mid_rst_b", 32'(b), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send_frame(f5, 1'b1);
    idle(2);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("frames_seen", 32'(frames_seen), 32'(frames_pushed));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
